// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB writeback register file with bypassed reads and retirement tracking (optional WB_REGFILE_DIFF_EN)
module wb_regfile #(
    parameter int              XLEN       = 64,
    parameter int              NREG       = 32,
    parameter int              AW         = 5,
    parameter logic [XLEN-1:0] INVALID_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_wreg_i,
    input  logic [AW-1:0]   wb_rd_addr_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic            wb_stall_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic [AW-1:0]   commit_rd_o,
    output logic [XLEN-1:0] commit_wdata_o,
    output logic [63:0]     instret_o
);

    logic [XLEN-1:0] regs [NREG];
    logic            wen;

    assign wen = wb_wreg_i && (wb_rd_addr_i != '0);

    // A stalled MEM/WB simply rewrites the same value, so stall does not gate writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[wb_rd_addr_i] <= wb_wdata_i;
        end
    end

    always_comb begin
        rdata1_o = regs[raddr1_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wen && (wb_rd_addr_i == raddr1_i)) begin
            rdata1_o = wb_wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs[raddr2_i];
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wen && (wb_rd_addr_i == raddr2_i)) begin
            rdata2_o = wb_wdata_i;
        end
    end

`ifdef WB_REGFILE_DIFF_EN
    logic retire;

    assign retire = !wb_stall_i && (wb_pc_i != INVALID_PC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_valid_o <= 1'b0;
            commit_pc_o    <= INVALID_PC;
            commit_rd_o    <= '0;
            commit_wdata_o <= '0;
            instret_o      <= '0;
        end else if (retire) begin
            commit_valid_o <= 1'b1;
            commit_pc_o    <= wb_pc_i;
            commit_rd_o    <= wen ? wb_rd_addr_i : '0;
            commit_wdata_o <= wen ? wb_wdata_i : '0;
            instret_o      <= instret_o + 64'd1;
        end else begin
            commit_valid_o <= 1'b0;
        end
    end
`else
    logic unused_diff;

    assign unused_diff    = ^{wb_pc_i, wb_stall_i};
    assign commit_valid_o = 1'b0;
    assign commit_pc_o    = INVALID_PC;
    assign commit_rd_o    = '0;
    assign commit_wdata_o = '0;
    assign instret_o      = '0;
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side receiver of the MEM/WB stage: a 32 x 64-bit integer register file.
- Accepts the registered writeback triple (rd address, write enable, data) plus the retiring PC.
- Provides two decode-stage read ports with same-cycle write bypass.
- Tracks retirement: registered commit record and retired-instruction counter for difftest/perf.

Parameters:
- XLEN, 64, register and data width.
- NREG, 32, number of architectural registers; x0 hardwired to zero.
- AW, 5, register address width (log2 NREG).
- INVALID_PC, 64'h0, PC value marking a bubble; never counted as a retirement.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- wb_wreg_i  in  1  write enable from MEM/WB.
- wb_rd_addr_i  in  AW  destination register.
- wb_wdata_i  in  XLEN  writeback data.
- wb_pc_i  in  XLEN  PC of the instruction in WB; INVALID_PC = bubble.
- wb_stall_i  in  1  WB held by pipeline control (MEM/WB is not advancing this cycle).
- raddr1_i  in  AW  read port 1 address.
- raddr2_i  in  AW  read port 2 address.
- rdata1_o  out  XLEN  read port 1 data (combinational).
- rdata2_o  out  XLEN  read port 2 data (combinational).
- commit_valid_o  out  1  registered: one instruction retired last cycle.
- commit_pc_o  out  XLEN  registered PC of that instruction.
- commit_rd_o  out  AW  registered rd (0 if no write).
- commit_wdata_o  out  XLEN  registered written value (0 if no write).
- instret_o  out  64  retired-instruction count.

Behaviour:
- Reset (rst==0 at an edge):
  - All registers x0..x31 <= 0; commit_valid_o <= 0, commit_pc_o <= INVALID_PC, commit_rd_o <= 0, commit_wdata_o <= 0, instret_o <= 0.
  - Writes presented during reset are discarded.
  - Reset asserted mid-stream takes precedence over any write or commit in that cycle.
- Write:
  - Enabled when wb_wreg_i==1 and wb_rd_addr_i!=0; reg[wb_rd_addr_i] <= wb_wdata_i at the edge.
  - Writes to x0 are ignored.
  - Writes are not gated by wb_stall_i: a held MEM/WB rewrites the same value, which is idempotent.
- Read (combinational, zero latency):
  - rdataN_o = 0 if raddrN_i==0.
  - Otherwise, if the write is enabled and wb_rd_addr_i==raddrN_i, rdataN_o = wb_wdata_i (bypass).
  - Otherwise rdataN_o = reg[raddrN_i].
  - Both ports are independent; both may hit the bypass in the same cycle.
- Commit (1-cycle latency):
  - retire = rst && !wb_stall_i && (wb_pc_i != INVALID_PC).
  - On retire: commit_valid_o <= 1, commit_pc_o <= wb_pc_i.
  - commit_rd_o / commit_wdata_o <= rd/wdata if the write is enabled, else 0.
  - Without retire: commit_valid_o <= 0; the other commit fields hold their values.
  - A stall lasting N cycles yields exactly one retirement: the cycle in which stall is low.
- instret_o:
  - Increments by 1 on each retire edge.
  - Wraps 2^64-1 -> 0 with no flag.

Optional Feature:
- Macro: WB_REGFILE_DIFF_EN.
- Defined: commit_* outputs and instret_o are implemented as above.
- Undefined:
  - No commit or counter flops are built; commit_valid_o=0, commit_pc_o=INVALID_PC, commit_rd_o=0, commit_wdata_o=0, instret_o=0 as constants.
  - Register file and read behaviour are unchanged.

Test Plan:
- Reset then read: hold rst=0 for 2 cycles while driving a write x5<=64'h1234; release. raddr1=5 -> rdata1_o=0, instret_o=0, commit_valid_o=0.
- Write then read: write x3<=64'hDEAD_BEEF at pc 64'h8000_0000. Next cycle raddr1=3 -> 64'hDEAD_BEEF; commit_valid_o=1, commit_pc_o=64'h8000_0000, commit_rd_o=3, instret_o=1.
- Bypass: in the same cycle, write x7<=64'hA5 with raddr1=raddr2=7 -> both rdata = 64'hA5 in that cycle. Writing x0<=64'hFF with raddr1=0 -> rdata1_o=0, and x0 stays 0 afterwards.
- Stall: hold pc 64'h8000_0010 with wb_stall_i=1 for 3 cycles, then 0 for 1 cycle -> exactly one commit_valid_o pulse with pc 64'h8000_0010; instret_o +1.
- Bubble: wb_pc_i=INVALID_PC, wb_wreg_i=0 for 4 cycles -> commit_valid_o stays 0, instret_o unchanged.
- Reset mid-stream: after 10 retirements, assert rst=0 for 1 cycle with a valid write x9 -> instret_o=0, x9 reads 0, commit_valid_o=0.
- Macro off: rerun the write-then-read test -> register results identical; all commit_* and instret_o outputs equal their constants.
